// File: rtl/multdiv.sv
// ============================================================================
// Module   : multdiv
// Purpose  : Iterative 32-bit signed multiply (shift-add) / divide (restoring).
// Revision : 1.0
// ============================================================================
`default_nettype none

module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_m;
  logic        r_neg;
  logic        r_dz;
  logic        r_dovf;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;

  logic        w_start;
  logic        w_last;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_acc;
  logic [63:0] w_prod;
  logic        w_mul_ovf;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [63:0] w_div_acc;
  logic [31:0] w_quo;
  logic [31:0] w_fin_result;
  logic        w_fin_exc;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_cnt == 6'd31);

  // Any start pulse wins over the current state, aborting work in flight.
  always_comb begin
    w_next = r_state;
    if (ctrl_MULT) begin
      w_next = MUL;
    end else if (ctrl_DIV) begin
      w_next = DIV;
    end else begin
      case (r_state)
        MUL:     if (w_last) w_next = DONE;
        DIV:     if (w_last) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  assign w_a_mag = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign w_b_mag = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // Multiply step: high half accumulates the multiplicand, low half holds multiplier bits.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
  assign w_mul_acc = {w_mul_sum, r_acc[31:1]};
  assign w_prod    = r_neg ? (~w_mul_acc + 64'd1) : w_mul_acc;
  assign w_mul_ovf = (w_prod[63:32] != {32{w_prod[31]}});

  // Divide step: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign w_rem_sh  = r_acc[63:31];
  assign w_diff    = w_rem_sh - {1'b0, r_m};
  assign w_div_acc = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                : {w_diff[31:0],   r_acc[30:0], 1'b1};
  assign w_quo     = r_neg ? (~w_div_acc[31:0] + 32'd1) : w_div_acc[31:0];

  always_comb begin
    w_fin_result = 32'd0;
    w_fin_exc    = 1'b0;
    if (r_state == MUL) begin
      w_fin_result = w_prod[31:0];
      w_fin_exc    = w_mul_ovf;
    end else if (r_dz) begin
      w_fin_result = 32'd0;
      w_fin_exc    = 1'b1;
    end else if (r_dovf) begin
      w_fin_result = 32'h8000_0000;
      w_fin_exc    = 1'b1;
    end else begin
      w_fin_result = w_quo;
      w_fin_exc    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_m      <= 32'd0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_dovf   <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_cnt  <= 6'd0;
        r_m    <= ctrl_MULT ? w_a_mag : w_b_mag;
        r_acc  <= ctrl_MULT ? {32'd0, w_b_mag} : {32'd0, w_a_mag};
        r_neg  <= data_operandA[31] ^ data_operandB[31];
        r_dz   <= (data_operandB == 32'd0);
        r_dovf <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      end else if ((r_state == MUL) || (r_state == DIV)) begin
        r_acc <= (r_state == MUL) ? w_mul_acc : w_div_acc;
        r_cnt <= r_cnt + 6'd1;
        if (w_last) begin
          r_result <= w_fin_result;
          r_exc    <= w_fin_exc;
          r_rdy    <= 1'b1;
        end
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

`default_nettype wire

// File: tb/tb_multdiv.sv
// ============================================================================
// Module   : tb_multdiv
// Purpose  : Scoreboard bench for multdiv with directed hand-computed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multdiv;

  logic        clk;
  logic        rst;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cmul;
  logic        cdiv;
  logic [31:0] res;
  logic        exc;
  logic        rdy;

  int n_checks;
  int n_fail;
  int cyc;

  typedef struct {
    int          at;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t q[$];

  multdiv dut (
    .clock          (clk),
    .reset          (rst),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .ctrl_MULT      (cmul),
    .ctrl_DIV       (cdiv),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every RDY strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rdy === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdy: got RDY=1 expected no strobe (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rdy_cycle", cyc, e.at);
        check("result", res, e.res);
        check("exception", {31'd0, exc}, {31'd0, e.exc});
      end
    end
  end

  // Issue a start pulse on the next cycle; scramble operands afterwards.
  task automatic issue(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic expect_it,
                       input logic [31:0] er, input logic ee, output int c);
    exp_t e;
    @(negedge clk);
    opa  = a;
    opb  = b;
    cmul = m;
    cdiv = d;
    c    = cyc;
    if (expect_it) begin
      e.at  = cyc + 33;
      e.res = er;
      e.exc = ee;
      q.push_back(e);
    end
    @(negedge clk);
    cmul = 1'b0;
    cdiv = 1'b0;
    opa  = $urandom;
    opb  = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (q.size() != 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic m, input logic d, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic ee);
    int c;
    issue(m, d, a, b, 1'b1, er, ee, c);
    wait_done();
  endtask

  initial begin
    int c0;
    int c1;
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    cmul = 1'b0;
    cdiv = 1'b0;
    opa  = 32'd0;
    opb  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_result", res, 32'd0);
    check("reset_exc", {31'd0, exc}, 32'd0);
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    rst = 1'b0;

    run(1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run(1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    run(1'b1, 1'b0, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0);
    run(1'b1, 1'b0, 32'hFFFF_FFFB,  32'd4,         32'hFFFF_FFEC, 1'b0);
    run(1'b1, 1'b0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1);
    run(1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    run(1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    run(1'b0, 1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1);
    run(1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run(1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);

    repeat (6) @(negedge clk);
    check("hold_result", res, 32'hFFFF_FFF2);
    check("hold_rdy", {31'd0, rdy}, 32'd0);

    // Divide aborted ten cycles in by a multiply.
    issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, c0);
    repeat (8) @(negedge clk);
    issue(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, c1);
    check("abort_spacing", c1 - c0, 32'd10);
    wait_done();

    run(1'b1, 1'b1, 32'd9, 32'd3, 32'd27, 1'b0);

    // Asynchronous reset mid-multiply.
    issue(1'b1, 1'b0, 32'd7, 32'd3, 1'b0, 32'd0, 1'b0, c0);
    while (cyc < c0 + 15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result", res, 32'd0);
    check("async_rst_exc", {31'd0, exc}, 32'd0);
    check("async_rst_rdy", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    while (cyc < c0 + 41) @(negedge clk);

    run(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);
    check("queue_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 The block SHALL have no parameters; operand and result width is fixed at 32 bits.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_operandA  input  32  signed two's-complement multiplicand or dividend.
REQ-005 data_operandB  input  32  signed two's-complement multiplier or divisor.
REQ-006 ctrl_MULT  input  1  single-cycle start pulse for a multiply.
REQ-007 ctrl_DIV  input  1  single-cycle start pulse for a divide.
REQ-008 data_result  output  32  registered product (low 32 bits) or quotient.
REQ-009 data_exception  output  1  registered flag for overflow or divide-by-zero, valid with data_result.
REQ-010 data_resultRDY  output  1  single-cycle completion strobe.

Function
REQ-011 Operands SHALL be sampled only on the rising edge where ctrl_MULT or ctrl_DIV is high; later operand changes SHALL have no effect.
REQ-012 If ctrl_MULT and ctrl_DIV are both high in the same cycle, a multiply SHALL be started.
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 FSM transitions: IDLE->MUL on ctrl_MULT; IDLE->DIV on ctrl_DIV; MUL/DIV->DONE after exactly 32 iterations; DONE->IDLE unconditionally.
REQ-015 Each iteration SHALL process one operand bit per clock, using a 6-bit counter that clears on start.
REQ-016 Multiply SHALL be radix-2 shift-add on magnitudes with sign correction, forming a full 64-bit signed product.
REQ-017 Divide SHALL be restoring division on magnitudes, with the quotient truncated toward zero and its sign equal to the XOR of the operand signs; the remainder is discarded.
REQ-018 If ctrl is high in cycle C, data_resultRDY SHALL be high in cycle C+33 only, for exactly one cycle.
REQ-019 data_result and data_exception SHALL update only on the edge that enters DONE, and SHALL hold until the next completion or reset.
REQ-020 Multiply overflow: if the 64-bit product is not the sign extension of its low 32 bits, data_exception SHALL be 1 and data_result SHALL be the low 32 bits.
REQ-021 Divide-by-zero (B=0): data_result SHALL be 0 and data_exception SHALL be 1.
REQ-022 Divide overflow (A=0x80000000, B=0xFFFFFFFF): data_result SHALL be 0x80000000 and data_exception SHALL be 1.
REQ-023 Otherwise data_exception SHALL be 0.
REQ-024 A start pulse received in MUL, DIV or DONE SHALL abort the current operation, with no RDY strobe for the aborted operation, and restart with the newly sampled operands; latency is counted per REQ-018 from the new pulse.
REQ-025 While in IDLE with no ctrl pulse, all outputs SHALL hold their values.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for a clock edge, force the state to IDLE, the counter to 0, data_result to 0, data_exception to 0 and data_resultRDY to 0.
REQ-027 Reset asserted mid-operation SHALL discard that operation; no RDY strobe SHALL follow its release.
REQ-028 After reset deasserts, the first ctrl pulse SHALL be accepted on the next rising edge.

Verification
REQ-029 MULT 7 x -3 pulsed in cycle C -> RDY only in cycle C+33, result 0xFFFFFFEB, exception 0.
REQ-030 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1; MULT 0x7FFFFFFF x 1 -> 0x7FFFFFFF, exception 0.
REQ-031 DIV -7 / 2 -> result 0xFFFFFFFD (-3), exception 0; DIV 5 / 0 -> result 0, exception 1; DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
REQ-032 DIV 100/7 pulsed in cycle C, then MULT 6 x 7 pulsed in cycle C+10 -> no RDY at C+33; RDY at C+43 with result 42.
REQ-033 MULT started, reset pulsed asynchronously in cycle C+15 between edges -> outputs 0 immediately; no RDY through C+40.
REQ-034 ctrl_MULT and ctrl_DIV both pulsed with A=9, B=3 -> result 27, not 3.
